// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard unit.
// Optional forwarding is enabled with HAZARD_FWD_EN.
package hazard_pkg;
    localparam int RA_W_DEF = 4;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } hz_state_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write vector for long-latency results.
// Register 0 is never marked pending.
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set_i,
    input  logic [RA_W-1:0] set_addr_i,
    input  logic            clr_i,
    input  logic [RA_W-1:0] clr_addr_i,
    input  logic [RA_W-1:0] ra_i,
    input  logic [RA_W-1:0] rb_i,
    output logic            ra_hit_o,
    output logic            rb_hit_o,
    output logic            any_o
);
    localparam int NREG = 1 << RA_W;

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clr_i) begin
            pend_d[clr_addr_i] = 1'b0;
        end
        if (set_i && (set_addr_i != '0)) begin
            pend_d[set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign ra_hit_o = pend_q[ra_i];
    assign rb_hit_o = pend_q[rb_i];
    assign any_o    = |pend_q;
endmodule

// File: rtl/id_hazard_unit.sv
// ID-stage hazard detection, operand forwarding and multiplier tracking.
// Define HAZARD_FWD_EN to forward from EX/MEM and MEM/WB instead of stalling.
module id_hazard_unit
    import hazard_pkg::*;
#(
    parameter int RA_W    = RA_W_DEF,
    parameter int MUL_LAT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [RA_W-1:0] id_ra,
    input  logic [RA_W-1:0] id_rb,
    input  logic            id_ra_used,
    input  logic            id_rb_used,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_wr_en,
    input  logic            ex_is_load,
    input  logic            mul_start,
    input  logic            mul_done,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_wr_en,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_wr_en,
    output logic [1:0]      ra_selector,
    output logic [1:0]      rb_selector,
    output logic            stall,
    output logic            bubble,
    output logic            mul_busy
);
    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RA_W-1:0]  mrd_q, mrd_d;
    logic             sb_set, sb_clr;
    logic             sb_ra, sb_rb, sb_any;
    logic             done_now;
    logic             use_a, use_b;
    logic             lu_a, lu_b;
    logic             pend_a, pend_b;
    logic             struct_hz;
    logic             raw_hz;
    logic             hz;
    fwd_sel_t         ra_sel, rb_sel;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mrd_d   = mrd_q;
        sb_set  = 1'b0;
        sb_clr  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mul_start) begin
                    state_d = MUL_BUSY;
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                    mrd_d   = ex_rd;
                    sb_set  = 1'b1;
                end
            end
            MUL_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (mul_done || (cnt_q == CNT_W'(1))) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sb_clr  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mrd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mrd_q   <= mrd_d;
        end
    end

    reg_scoreboard #(
        .RA_W(RA_W)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_i     (sb_set),
        .set_addr_i(ex_rd),
        .clr_i     (sb_clr),
        .clr_addr_i(mrd_q),
        .ra_i      (id_ra),
        .rb_i      (id_rb),
        .ra_hit_o  (sb_ra),
        .rb_hit_o  (sb_rb),
        .any_o     (sb_any)
    );

    assign mul_busy = (state_q == MUL_BUSY);
    assign done_now = mul_busy & mul_done;

    assign use_a = id_ra_used & (id_ra != '0);
    assign use_b = id_rb_used & (id_rb != '0);

    assign lu_a = use_a & ex_is_load & ex_wr_en & (id_ra == ex_rd);
    assign lu_b = use_b & ex_is_load & ex_wr_en & (id_rb == ex_rd);

    // A result completing this cycle is forwarded, so its bit no longer blocks.
    assign pend_a = use_a & sb_ra & ~(done_now & (id_ra == mrd_q));
    assign pend_b = use_b & sb_rb & ~(done_now & (id_rb == mrd_q));

    assign struct_hz = mul_busy & sb_any & ~done_now;

`ifdef HAZARD_FWD_EN
    function automatic fwd_sel_t pick(
        input logic [RA_W-1:0] src,
        input logic            used
    );
        if (!used) begin
            return FWD_RF;
        end else if (mem_wr_en && (src == mem_rd)) begin
            return FWD_EXMEM;
        end else if (wb_wr_en && (src == wb_rd)) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

    assign ra_sel = pick(id_ra, use_a);
    assign rb_sel = pick(id_rb, use_b);
    assign raw_hz = 1'b0;
`else
    assign ra_sel = FWD_RF;
    assign rb_sel = FWD_RF;
    assign raw_hz =
        (use_a & ((ex_wr_en & (id_ra == ex_rd)) |
                  (mem_wr_en & (id_ra == mem_rd)) |
                  (wb_wr_en & (id_ra == wb_rd)))) |
        (use_b & ((ex_wr_en & (id_rb == ex_rd)) |
                  (mem_wr_en & (id_rb == mem_rd)) |
                  (wb_wr_en & (id_rb == wb_rd))));
`endif

    assign ra_selector = ra_sel;
    assign rb_selector = rb_sel;

    assign hz = rst_n & id_valid &
                (lu_a | lu_b | pend_a | pend_b | struct_hz | raw_hz);

    assign stall  = hz;
    assign bubble = hz;
endmodule

// File: tb/tb_id_hazard_unit.sv
// Randomized and directed checks of id_hazard_unit against a rule-level model.
// Expectations follow the same HAZARD_FWD_EN setting as the design.
module tb_id_hazard_unit;
    localparam int RA_W    = 4;
    localparam int MUL_LAT = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_valid;
    logic [RA_W-1:0] id_ra, id_rb;
    logic            id_ra_used, id_rb_used;
    logic [RA_W-1:0] ex_rd;
    logic            ex_wr_en, ex_is_load;
    logic            mul_start, mul_done;
    logic [RA_W-1:0] mem_rd;
    logic            mem_wr_en;
    logic [RA_W-1:0] wb_rd;
    logic            wb_wr_en;
    logic [1:0]      ra_selector, rb_selector;
    logic            stall, bubble, mul_busy;

    int n_chk = 0;
    int n_err = 0;

    // model: one outstanding multiply, its target and busy cycles left
    bit m_busy = 1'b0;
    int m_rd   = 0;
    int m_left = 0;

    logic obs_stall, obs_busy;
    logic [1:0] obs_ra, obs_rb;

    always #5 clk = ~clk;

    id_hazard_unit #(
        .RA_W   (RA_W),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_ra      (id_ra),
        .id_rb      (id_rb),
        .id_ra_used (id_ra_used),
        .id_rb_used (id_rb_used),
        .ex_rd      (ex_rd),
        .ex_wr_en   (ex_wr_en),
        .ex_is_load (ex_is_load),
        .mul_start  (mul_start),
        .mul_done   (mul_done),
        .mem_rd     (mem_rd),
        .mem_wr_en  (mem_wr_en),
        .wb_rd      (wb_rd),
        .wb_wr_en   (wb_wr_en),
        .ra_selector(ra_selector),
        .rb_selector(rb_selector),
        .stall      (stall),
        .bubble     (bubble),
        .mul_busy   (mul_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_sel(input int src, input bit used);
`ifdef HAZARD_FWD_EN
        if (!used || src == 0) return 0;
        if (mem_wr_en && int'(mem_rd) == src) return 1;
        if (wb_wr_en && int'(wb_rd) == src) return 2;
        return 0;
`else
        return 0;
`endif
    endfunction

    function automatic bit src_hazard(input int s, input bit used);
        bit clearing;
        if (!used || s == 0) return 1'b0;
        clearing = m_busy && mul_done;
        if (ex_is_load && ex_wr_en && int'(ex_rd) == s) return 1'b1;
        if (m_busy && !clearing && m_rd == s) return 1'b1;
`ifndef HAZARD_FWD_EN
        if (ex_wr_en && int'(ex_rd) == s) return 1'b1;
        if (mem_wr_en && int'(mem_rd) == s) return 1'b1;
        if (wb_wr_en && int'(wb_rd) == s) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        bit structural;
        if (!rst_n || !id_valid) return 1'b0;
        structural = m_busy && !mul_done && m_rd != 0;
        return structural ||
               src_hazard(int'(id_ra), id_ra_used) ||
               src_hazard(int'(id_rb), id_rb_used);
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (mul_start) begin
                m_busy = 1'b1;
                m_rd   = int'(ex_rd);
                m_left = MUL_LAT - 1;
            end
        end else begin
            m_left--;
            if (mul_done || m_left == 0) m_busy = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        obs_stall = stall;
        obs_busy  = mul_busy;
        obs_ra    = ra_selector;
        obs_rb    = rb_selector;
        chk("stall", 32'(stall), 32'(m_stall()));
        chk("bubble_eq", 32'(bubble), 32'(stall));
        chk("mul_busy", 32'(mul_busy), 32'(m_busy));
        chk("ra_sel", 32'(ra_selector), 32'(m_sel(int'(id_ra), id_ra_used)));
        chk("rb_sel", 32'(rb_selector), 32'(m_sel(int'(id_rb), id_rb_used)));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        rst_n = 1'b1; id_valid = 1'b0;
        id_ra = '0; id_rb = '0; id_ra_used = 1'b0; id_rb_used = 1'b0;
        ex_rd = '0; ex_wr_en = 1'b0; ex_is_load = 1'b0;
        mul_start = 1'b0; mul_done = 1'b0;
        mem_rd = '0; mem_wr_en = 1'b0; wb_rd = '0; wb_wr_en = 1'b0;
    endtask

    initial begin
        int cnt;
        quiet();
        rst_n = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
        tick();
        chk("rst_stall", 32'(obs_stall), 32'd0);
        chk("rst_busy", 32'(obs_busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // EX/MEM beats MEM/WB on the same source
        quiet();
        id_valid = 1; id_rb = 3; id_rb_used = 1;
        mem_rd = 3; mem_wr_en = 1; wb_rd = 3; wb_wr_en = 1;
        tick();
`ifdef HAZARD_FWD_EN
        chk("prio_rb", 32'(obs_rb), 32'd1);
`else
        chk("prio_rb_stall", 32'(obs_stall), 32'd1);
`endif

        // R0 never forwards or stalls
        quiet();
        id_valid = 1; id_ra = 0; id_ra_used = 1; mem_rd = 0; mem_wr_en = 1;
        tick();
        chk("r0_sel", 32'(obs_ra), 32'd0);
        chk("r0_stall", 32'(obs_stall), 32'd0);

        // load-use then forward from EX/MEM
        quiet();
        id_valid = 1; id_ra = 5; id_ra_used = 1;
        ex_rd = 5; ex_wr_en = 1; ex_is_load = 1;
        tick();
        chk("lu_stall", 32'(obs_stall), 32'd1);
        ex_wr_en = 0; ex_is_load = 0; mem_rd = 5; mem_wr_en = 1;
        tick();
`ifdef HAZARD_FWD_EN
        chk("lu_fwd_sel", 32'(obs_ra), 32'd1);
        chk("lu_fwd_stall", 32'(obs_stall), 32'd0);
`else
        chk("nofwd_mem", 32'(obs_stall), 32'd1);
        mem_wr_en = 0; wb_rd = 5; wb_wr_en = 1;
        tick();
        chk("nofwd_wb", 32'(obs_stall), 32'd1);
        wb_wr_en = 0;
        tick();
        chk("nofwd_gone", 32'(obs_stall), 32'd0);
`endif

        // multiply to R7 holds a consumer for MUL_LAT-1 cycles
        quiet();
        mul_start = 1; ex_rd = 7;
        tick();
        mul_start = 0; ex_rd = 0;
        id_valid = 1; id_rb = 7; id_rb_used = 1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (obs_stall) cnt++;
        end
        chk("mul_stall_len", 32'(cnt), 32'(MUL_LAT - 1));
        chk("mul_busy_fall", 32'(obs_busy), 32'd0);

        // reset during a multiply, then a stray done
        quiet();
        mul_start = 1; ex_rd = 7;
        tick();
        mul_start = 0; id_valid = 1; id_rb = 7; id_rb_used = 1;
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        chk("rst_mid_busy", 32'(obs_busy), 32'd0);
        chk("rst_mid_stall", 32'(obs_stall), 32'd0);
        mul_done = 1;
        tick();
        mul_done = 0;
        tick();
        chk("stray_done", 32'(obs_busy), 32'd0);

        // completion and hit in the same cycle
        quiet();
        mul_start = 1; ex_rd = 9;
        tick();
        mul_start = 0; ex_rd = 0;
        id_valid = 1; id_ra = 9; id_ra_used = 1;
        tick();
        chk("hit_stall", 32'(obs_stall), 32'd1);
        mul_done = 1; mem_rd = 9; mem_wr_en = 1;
        tick();
`ifdef HAZARD_FWD_EN
        chk("clr_wins_stall", 32'(obs_stall), 32'd0);
        chk("clr_wins_sel", 32'(obs_ra), 32'd1);
`else
        chk("clr_nofwd", 32'(obs_stall), 32'd1);
`endif
        quiet();
        tick();

        // invalid ID never stalls
        quiet();
        id_ra = 5; id_ra_used = 1; ex_rd = 5; ex_wr_en = 1; ex_is_load = 1;
        tick();
        chk("novalid", 32'(obs_stall), 32'd0);

        for (int i = 0; i < 400; i++) begin
            rst_n      = ($urandom_range(0, 49) != 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_ra      = RA_W'($urandom_range(0, 7));
            id_rb      = RA_W'($urandom_range(0, 7));
            id_ra_used = ($urandom_range(0, 3) != 0);
            id_rb_used = ($urandom_range(0, 3) != 0);
            ex_rd      = RA_W'($urandom_range(0, 7));
            ex_wr_en   = $urandom_range(0, 1) == 1;
            ex_is_load = ($urandom_range(0, 3) == 0);
            mul_start  = ($urandom_range(0, 9) == 0);
            mul_done   = ($urandom_range(0, 9) == 0);
            mem_rd     = RA_W'($urandom_range(0, 7));
            mem_wr_en  = $urandom_range(0, 1) == 1;
            wb_rd      = RA_W'($urandom_range(0, 7));
            wb_wr_en   = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
